// File: rtl/address_map_pkg.sv
// Shared definitions for the SNES address map: config field codes, flag bit
// positions, the window-entry record and both FSM state encodings.
package address_map_pkg;

   // Width of address fields held in a window entry; address_map.ADDR_W must match.
   localparam int unsigned ENTRY_W = 24;

   localparam logic [1:0] FIELD_MATCH_BASE  = 2'd0;
   localparam logic [1:0] FIELD_MATCH_MASK  = 2'd1;
   localparam logic [1:0] FIELD_TARGET_BASE = 2'd2;
   localparam logic [1:0] FIELD_XLAT_MASK   = 2'd3;

   localparam int unsigned FLAG_ENABLE     = 0;
   localparam int unsigned FLAG_LOROM_PACK = 1;
   localparam int unsigned FLAG_SAVERAM    = 2;
   localparam int unsigned FLAG_WRITABLE   = 3;

   typedef struct packed {
      logic               enable;
      logic               lorom_pack;
      logic               saveram;
      logic               writable;
      logic [ENTRY_W-1:0] match_base;
      logic [ENTRY_W-1:0] match_mask;
      logic [ENTRY_W-1:0] target_base;
      logic [ENTRY_W-1:0] xlat_mask;
   } win_entry_t;

   localparam logic COMMIT_IDLE    = 1'b0;
   localparam logic COMMIT_PENDING = 1'b1;

   localparam logic [1:0] UNLOCK_LOCKED   = 2'd0;
   localparam logic [1:0] UNLOCK_UNLOCKED = 2'd1;
   localparam logic [1:0] UNLOCK_DRAIN    = 2'd2;

endpackage

// File: rtl/address_map_window_match.sv
// Single decode window: address compare against one active entry plus the
// translated ROM address that window would produce.
module addr_window_match
   import address_map_pkg::*;
#(
   parameter int unsigned ADDR_W = ENTRY_W
) (
   input  win_entry_t        entry_i,
   input  logic [ADDR_W-1:0] snes_addr_i,
   output logic              match_o,
   output logic              saveram_o,
   output logic              writable_o,
   output logic [ADDR_W-1:0] rom_addr_o
);

   logic [ADDR_W-1:0] packed_addr;

   always_comb begin
      // LoROM packing drops bit 15 so 32 KiB banks become contiguous.
      packed_addr = entry_i.lorom_pack ?
                    {1'b0, snes_addr_i[ADDR_W-1:16], snes_addr_i[14:0]} : snes_addr_i;
      match_o     = entry_i.enable &&
                    ((snes_addr_i & entry_i.match_mask) == entry_i.match_base);
      rom_addr_o  = entry_i.target_base | (packed_addr & entry_i.xlat_mask);
      saveram_o   = entry_i.saveram;
      writable_o  = entry_i.writable;
   end

endmodule

// File: rtl/address_map.sv
// Programmable SNES-to-ROM address decoder with shadow/active window tables,
// a bus-idle-gated commit and a time-limited patch-unlock window.
module address_map
   import address_map_pkg::*;
#(
   parameter int unsigned NUM_WIN     = 4,
   parameter int unsigned ADDR_W      = ENTRY_W,
   parameter int unsigned UNLOCK_HOLD = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [ADDR_W-1:0]  SNES_ADDR,
   input  logic               snes_idle,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_idx,
   input  logic [1:0]         cfg_field,
   input  logic [ADDR_W-1:0]  cfg_data,
   input  logic [3:0]         cfg_flags,
   input  logic               cfg_commit,
   output logic               cfg_busy,
   input  logic               unlock_set,
   input  logic               unlock_clr,
   output logic [ADDR_W-1:0]  ROM_ADDR,
   output logic               ROM_HIT,
   output logic               IS_ROM,
   output logic               IS_SAVERAM,
   output logic               IS_WRITABLE,
   output logic [NUM_WIN-1:0] win_hit,
   output logic               map_unlock
);

   win_entry_t        shadow_q [NUM_WIN];
   win_entry_t        shadow_d [NUM_WIN];
   win_entry_t        active_q [NUM_WIN];
   logic              commit_q, commit_d, apply;
   logic [1:0]        unlock_q, unlock_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [NUM_WIN-1:0] match, win_saveram, win_writable;
   logic [ADDR_W-1:0]  win_addr [NUM_WIN];
   logic               patch_hit, found;
   logic [NUM_WIN-1:0] hit_d;
   logic [ADDR_W-1:0]  addr_d;
   logic               rom_d, saveram_d, writable_d;

   always_comb begin
      for (int i = 0; i < NUM_WIN; i++) begin
         shadow_d[i] = shadow_q[i];
         if (cfg_we && cfg_idx == 3'(i)) begin
            unique case (cfg_field)
               FIELD_MATCH_BASE: begin
                  shadow_d[i].match_base = cfg_data;
                  shadow_d[i].enable     = cfg_flags[FLAG_ENABLE];
                  shadow_d[i].lorom_pack = cfg_flags[FLAG_LOROM_PACK];
                  shadow_d[i].saveram    = cfg_flags[FLAG_SAVERAM];
                  shadow_d[i].writable   = cfg_flags[FLAG_WRITABLE];
               end
               FIELD_MATCH_MASK:  shadow_d[i].match_mask  = cfg_data;
               FIELD_TARGET_BASE: shadow_d[i].target_base = cfg_data;
               FIELD_XLAT_MASK:   shadow_d[i].xlat_mask   = cfg_data;
            endcase
         end
      end
   end

   always_comb begin
      commit_d = commit_q;
      apply    = 1'b0;
      case (commit_q)
         COMMIT_IDLE: if (cfg_commit) commit_d = COMMIT_PENDING;
         default: begin
            if (snes_idle) begin
               commit_d = COMMIT_IDLE;
               apply    = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      unlock_d = unlock_q;
      cnt_d    = cnt_q;
      case (unlock_q)
         UNLOCK_LOCKED: if (unlock_set) unlock_d = UNLOCK_UNLOCKED;
         UNLOCK_UNLOCKED: begin
            if (!unlock_set && unlock_clr) begin
               unlock_d = UNLOCK_DRAIN;
               cnt_d    = 8'(UNLOCK_HOLD - 1);
            end
         end
         UNLOCK_DRAIN: begin
            if (unlock_set)        unlock_d = UNLOCK_UNLOCKED;
            else if (cnt_q == 8'd0) unlock_d = UNLOCK_LOCKED;
            else                   cnt_d    = cnt_q - 8'd1;
         end
         default: unlock_d = UNLOCK_LOCKED;
      endcase
   end

   assign cfg_busy   = (commit_q == COMMIT_PENDING);
   assign map_unlock = (unlock_q == UNLOCK_UNLOCKED) || (unlock_q == UNLOCK_DRAIN);
   assign patch_hit  = map_unlock && (&SNES_ADDR[ADDR_W-1:ADDR_W-4]);

   for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
      addr_window_match #(
         .ADDR_W (ADDR_W)
      ) u_match (
         .entry_i     (active_q[g]),
         .snes_addr_i (SNES_ADDR),
         .match_o     (match[g]),
         .saveram_o   (win_saveram[g]),
         .writable_o  (win_writable[g]),
         .rom_addr_o  (win_addr[g])
      );
   end

   always_comb begin
      hit_d      = '0;
      addr_d     = '0;
      rom_d      = 1'b0;
      saveram_d  = 1'b0;
      writable_d = 1'b0;
      found      = 1'b0;
      if (patch_hit) begin
         addr_d     = SNES_ADDR;
         writable_d = 1'b1;
      end else begin
         for (int i = 0; i < NUM_WIN; i++) begin
            if (!found && match[i]) begin
               found      = 1'b1;
               hit_d[i]   = 1'b1;
               addr_d     = win_addr[i];
               saveram_d  = win_saveram[i];
               writable_d = win_writable[i];
               rom_d      = !win_saveram[i];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_WIN; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         commit_q    <= COMMIT_IDLE;
         unlock_q    <= UNLOCK_LOCKED;
         cnt_q       <= '0;
         ROM_ADDR    <= '0;
         ROM_HIT     <= 1'b0;
         IS_ROM      <= 1'b0;
         IS_SAVERAM  <= 1'b0;
         IS_WRITABLE <= 1'b0;
         win_hit     <= '0;
      end else begin
         shadow_q <= shadow_d;
         // Copy the post-write shadow so a same-edge cfg_we lands in this commit.
         if (apply) active_q <= shadow_d;
         commit_q    <= commit_d;
         unlock_q    <= unlock_d;
         cnt_q       <= cnt_d;
         ROM_ADDR    <= addr_d;
         ROM_HIT     <= rom_d | saveram_d | writable_d;
         IS_ROM      <= rom_d;
         IS_SAVERAM  <= saveram_d;
         IS_WRITABLE <= writable_d;
         win_hit     <= hit_d;
      end
   end

endmodule

// File: tb/tb_address_map.sv
// Randomized and directed bench for address_map against a behavioural model
// of the window table, commit handshake and unlock hold time.
module tb_address_map;

   localparam int unsigned HOLD = 16;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [23:0] SNES_ADDR;
   logic        snes_idle, cfg_we, cfg_commit, unlock_set, unlock_clr;
   logic [2:0]  cfg_idx;
   logic [1:0]  cfg_field;
   logic [23:0] cfg_data;
   logic [3:0]  cfg_flags;
   logic        cfg_busy, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE, map_unlock;
   logic [23:0] ROM_ADDR;
   logic [3:0]  win_hit;

   address_map #(
      .NUM_WIN     (4),
      .ADDR_W      (24),
      .UNLOCK_HOLD (HOLD)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .SNES_ADDR   (SNES_ADDR),
      .snes_idle   (snes_idle),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_field   (cfg_field),
      .cfg_data    (cfg_data),
      .cfg_flags   (cfg_flags),
      .cfg_commit  (cfg_commit),
      .cfg_busy    (cfg_busy),
      .unlock_set  (unlock_set),
      .unlock_clr  (unlock_clr),
      .ROM_ADDR    (ROM_ADDR),
      .ROM_HIT     (ROM_HIT),
      .IS_ROM      (IS_ROM),
      .IS_SAVERAM  (IS_SAVERAM),
      .IS_WRITABLE (IS_WRITABLE),
      .win_hit     (win_hit),
      .map_unlock  (map_unlock)
   );

   always #5 CLK = ~CLK;

   int unsigned m_sh [4][4];
   int unsigned m_ac [4][4];
   logic [3:0]  m_shf [4];
   logic [3:0]  m_acf [4];
   bit          m_pend;
   int          m_umode;    // 0 locked, 1 unlocked, 2 draining
   int          m_left;     // cycles map_unlock still stays high while draining
   int unsigned e_addr;
   logic [3:0]  e_hit;
   logic        e_rom, e_sav, e_wr, e_romhit;
   int          checks = 0;
   int          passes = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         for (int f = 0; f < 4; f++) begin
            m_sh[i][f] = 0;
            m_ac[i][f] = 0;
         end
         m_shf[i] = '0;
         m_acf[i] = '0;
      end
      m_pend = 0; m_umode = 0; m_left = 0;
      e_addr = 0; e_hit = '0; e_rom = 0; e_sav = 0; e_wr = 0; e_romhit = 0;
   endtask

   task automatic model_decode(input int unsigned a);
      bit          found;
      int unsigned p;
      found = 0;
      e_addr = 0; e_hit = '0; e_rom = 0; e_sav = 0; e_wr = 0;
      if (m_umode != 0 && (a >> 20) == 32'hF) begin
         e_addr = a;
         e_wr   = 1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!found && m_acf[i][0] && (a & m_ac[i][1]) == m_ac[i][0]) begin
               found    = 1;
               p        = m_acf[i][1] ? (((a >> 16) << 15) | (a & 32'h7FFF)) : a;
               e_addr   = (m_ac[i][2] | (p & m_ac[i][3])) & 32'hFFFFFF;
               e_hit[i] = 1'b1;
               e_sav    = m_acf[i][2];
               e_wr     = m_acf[i][3];
               e_rom    = !m_acf[i][2];
            end
         end
      end
      e_romhit = e_rom | e_sav | e_wr;
   endtask

   task automatic model_next();
      if (cfg_we && cfg_idx < 3'd4) begin
         m_sh[int'(cfg_idx)][int'(cfg_field)] = 32'(cfg_data);
         if (cfg_field == 2'd0) m_shf[int'(cfg_idx)] = cfg_flags;
      end
      if (m_pend) begin
         if (snes_idle) begin
            m_ac   = m_sh;
            m_acf  = m_shf;
            m_pend = 0;
         end
      end else if (cfg_commit) begin
         m_pend = 1;
      end
      if (unlock_set) begin
         m_umode = 1;
      end else if (m_umode == 1 && unlock_clr) begin
         m_umode = 2;
         m_left  = HOLD;
      end else if (m_umode == 2) begin
         m_left--;
         if (m_left == 0) m_umode = 0;
      end
   endtask

   task automatic tick();
      model_decode(32'(SNES_ADDR));
      model_next();
      @(posedge CLK);
      #1;
      check("rom_addr", 32'(ROM_ADDR), e_addr);
      check("win_hit", 32'(win_hit), 32'(e_hit));
      check("is_rom", 32'(IS_ROM), 32'(e_rom));
      check("is_saveram", 32'(IS_SAVERAM), 32'(e_sav));
      check("is_writable", 32'(IS_WRITABLE), 32'(e_wr));
      check("rom_hit", 32'(ROM_HIT), 32'(e_romhit));
      check("cfg_busy", 32'(cfg_busy), 32'(m_pend));
      check("map_unlock", 32'(map_unlock), 32'(m_umode != 0));
   endtask

   task automatic cfg_write(input int idx, input int field, input logic [23:0] data,
                            input logic [3:0] flags);
      cfg_we = 1; cfg_idx = 3'(idx); cfg_field = 2'(field); cfg_data = data; cfg_flags = flags;
      tick();
      cfg_we = 0;
   endtask

   task automatic do_commit();
      cfg_commit = 1;
      tick();
      cfg_commit = 0;
      for (int k = 0; k < 20 && cfg_busy; k++) tick();
      check("commit_done", 32'(cfg_busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"}, 32'(ROM_ADDR), 32'd0);
      check({tag, "_flags"}, 32'({ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}), 32'd0);
      check({tag, "_hit"}, 32'(win_hit), 32'd0);
      check({tag, "_busy"}, 32'(cfg_busy), 32'd0);
      check({tag, "_unlock"}, 32'(map_unlock), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [23:0] base_tab [4];
      logic [23:0] mask_tab [4];
      int          busy_cnt, n, j;
      base_tab[0] = 24'h700000; base_tab[1] = 24'h008000;
      base_tab[2] = 24'hC00000; base_tab[3] = 24'h000000;
      mask_tab[0] = 24'hF00000; mask_tab[1] = 24'h408000;
      mask_tab[2] = 24'hFF8000; mask_tab[3] = 24'hC00000;

      RST_N = 0; SNES_ADDR = '0; snes_idle = 1; cfg_we = 0; cfg_idx = '0; cfg_field = '0;
      cfg_data = '0; cfg_flags = '0; cfg_commit = 0; unlock_set = 0; unlock_clr = 0;
      model_reset();
      #3;
      check_all_zero("reset");
      #10;
      RST_N = 1;

      // LoROM window translation
      cfg_write(0, 0, 24'h008000, 4'b0011);
      cfg_write(0, 1, 24'h408000, 4'b0000);
      cfg_write(0, 2, 24'h000000, 4'b0000);
      cfg_write(0, 3, 24'h3FFFFF, 4'b0000);
      do_commit();
      SNES_ADDR = 24'h018123;
      tick();
      check("lorom_addr", 32'(ROM_ADDR), 32'h008123);
      check("lorom_is_rom", 32'(IS_ROM), 32'd1);

      // Priority between overlapping windows
      cfg_write(0, 0, 24'h700000, 4'b0001);
      cfg_write(0, 1, 24'hF00000, 4'b0000);
      cfg_write(0, 2, 24'h100000, 4'b0000);
      cfg_write(0, 3, 24'h0FFFFF, 4'b0000);
      cfg_write(1, 0, 24'h700000, 4'b0101);
      cfg_write(1, 1, 24'hFF0000, 4'b0000);
      cfg_write(1, 2, 24'h200000, 4'b0000);
      cfg_write(1, 3, 24'h00FFFF, 4'b0000);
      do_commit();
      SNES_ADDR = 24'h700000;
      tick();
      check("prio_hit0", 32'(win_hit), 32'b0001);
      check("prio_sav0", 32'(IS_SAVERAM), 32'd0);
      cfg_write(0, 0, 24'h700000, 4'b0000);
      do_commit();
      tick();
      check("prio_hit1", 32'(win_hit), 32'b0010);
      check("prio_sav1", 32'(IS_SAVERAM), 32'd1);

      // Commit held off by a busy SNES bus; writes while pending join the copy
      snes_idle = 0;
      cfg_write(1, 0, 24'h700000, 4'b0000);
      busy_cnt = 0;
      cfg_commit = 1;
      tick();
      cfg_commit = 0;
      if (cfg_busy) busy_cnt++;
      cfg_write(2, 1, 24'hF00000, 4'b0000);
      if (cfg_busy) busy_cnt++;
      cfg_write(2, 0, 24'h700000, 4'b1001);
      if (cfg_busy) busy_cnt++;
      tick();
      if (cfg_busy) busy_cnt++;
      tick();
      if (cfg_busy) busy_cnt++;
      check("held_old_table", 32'(win_hit), 32'b0010);
      snes_idle = 1;
      tick();
      check("busy_cycles", 32'(busy_cnt), 32'd5);
      check("apply_edge_old", 32'(win_hit), 32'b0010);
      tick();
      check("apply_new_hit", 32'(win_hit), 32'b0100);
      check("apply_new_wr", 32'(IS_WRITABLE), 32'd1);

      // Patch unlock and hold time
      SNES_ADDR = 24'hF01234;
      unlock_set = 1;
      tick();
      unlock_set = 0;
      tick();
      check("patch_addr", 32'(ROM_ADDR), 32'hF01234);
      check("patch_wr", 32'(IS_WRITABLE), 32'd1);
      check("patch_rom", 32'(IS_ROM), 32'd0);
      unlock_clr = 1;
      tick();
      unlock_clr = 0;
      n = 0;
      while (map_unlock && n < 40) begin
         tick();
         n++;
      end
      check("hold_cycles", 32'(n), 32'(HOLD));

      // Set and clear together while draining
      unlock_set = 1;
      tick();
      unlock_set = 0; unlock_clr = 1;
      tick();
      unlock_clr = 0;
      repeat (3) tick();
      unlock_set = 1; unlock_clr = 1;
      tick();
      unlock_set = 0; unlock_clr = 0;
      repeat (20) tick();
      check("set_wins", 32'(map_unlock), 32'd1);
      unlock_clr = 1;
      tick();
      unlock_clr = 0;

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         cfg_we     = ($urandom % 4) == 0;
         cfg_idx    = 3'($urandom);
         cfg_field  = 2'($urandom);
         cfg_flags  = 4'($urandom);
         if (cfg_field == 2'd0)      cfg_data = base_tab[$urandom % 4];
         else if (cfg_field == 2'd1) cfg_data = mask_tab[$urandom % 4];
         else                        cfg_data = 24'($urandom);
         cfg_commit = ($urandom % 8) == 0;
         snes_idle  = ($urandom % 2) == 0;
         unlock_set = ($urandom % 16) == 0;
         unlock_clr = ($urandom % 12) == 0;
         case ($urandom % 4)
            0: SNES_ADDR = 24'($urandom);
            1: SNES_ADDR = 24'h F00000 | 24'($urandom % 32'h100000);
            default: begin
               j = int'($urandom % 4);
               SNES_ADDR = 24'(m_ac[j][0] | ($urandom & ~m_ac[j][1]));
            end
         endcase
         tick();
      end
      cfg_we = 0; cfg_commit = 0; unlock_set = 0; unlock_clr = 0;

      // Reset while a commit is pending and the unlock is draining
      snes_idle = 0;
      unlock_set = 1;
      tick();
      unlock_set = 0; unlock_clr = 1;
      tick();
      unlock_clr = 0; cfg_commit = 1;
      tick();
      cfg_commit = 0;
      check("pre_reset_busy", 32'(cfg_busy), 32'd1);
      SNES_ADDR = 24'h700000;
      #2;
      RST_N = 0;
      model_reset();
      #1;
      check_all_zero("midreset");
      #1;
      RST_N = 1;
      snes_idle = 1;
      repeat (3) tick();
      check("post_reset_hit", 32'(win_hit), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/address_map.md
ADDRESS_MAP -- requirements
Module: address_map

Interface
REQ-001 NUM_WIN, 4, number of programmable decode windows (1..8).
REQ-002 ADDR_W, 24, SNES and ROM address width.
REQ-003 UNLOCK_HOLD, 16, cycles map_unlock stays high after an unlock-clear request (1..255).
REQ-004 CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 SNES_ADDR  in  ADDR_W  requested SNES address.
REQ-007 snes_idle  in  1  high when no SNES bus cycle is in progress.
REQ-008 cfg_we  in  1  shadow-table write strobe, one cycle.
REQ-009 cfg_idx  in  3  window index written; values >= NUM_WIN are ignored.
REQ-010 cfg_field  in  2  0=match_base, 1=match_mask, 2=target_base, 3=xlat_mask.
REQ-011 cfg_data  in  ADDR_W  field value; bits [ADDR_W-1:ADDR_W-4] of match_mask also carry no flags.
REQ-012 cfg_flags  in  4  per-window flags latched on field-0 writes: [0]=enable, [1]=lorom_pack, [2]=saveram, [3]=writable.
REQ-013 cfg_commit  in  1  request copy of shadow table to active table, one cycle.
REQ-014 cfg_busy  out  1  commit pending.
REQ-015 unlock_set / unlock_clr  in  1 each  patch-unlock request pulses.
REQ-016 ROM_ADDR  out  ADDR_W  translated address, registered.
REQ-017 ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE  out  1 each  registered decode flags.
REQ-018 win_hit  out  NUM_WIN  one-hot winning window, registered.
REQ-019 map_unlock  out  1  effective unlock state.

Function
REQ-020 Match for window i: enable & ((SNES_ADDR & match_mask) == match_base), using active table.
REQ-021 Priority: lowest matching index wins; win_hit one-hot or zero.
REQ-022 Packed address: lorom_pack ? {1'b0, SNES_ADDR[ADDR_W-1:16], SNES_ADDR[14:0]} : SNES_ADDR.
REQ-023 ROM_ADDR = target_base | (packed & xlat_mask), truncated to ADDR_W, no carry.
REQ-024 IS_SAVERAM = saveram flag of winner; IS_ROM = winner exists and not saveram; IS_WRITABLE = writable flag of winner or patch hit; ROM_HIT = IS_ROM | IS_WRITABLE | IS_SAVERAM.
REQ-025 Patch hit: map_unlock high and SNES_ADDR[ADDR_W-1:ADDR_W-4] all ones; overrides all windows, ROM_ADDR = SNES_ADDR, IS_WRITABLE=1, IS_ROM=0, IS_SAVERAM=0, win_hit=0.
REQ-026 No hit: ROM_ADDR=0, all flags 0, win_hit=0.
REQ-027 Decode latency: outputs reflect SNES_ADDR sampled one CLK earlier, every cycle.
REQ-028 cfg_we writes the shadow table only; active table unchanged until commit.
REQ-029 Commit FSM IDLE->PENDING on cfg_commit; PENDING->IDLE on first cycle with snes_idle=1, copying all shadow entries atomically that edge; cfg_busy = (state==PENDING).
REQ-030 cfg_commit with snes_idle=1 in IDLE applies on the next edge (one cycle PENDING).
REQ-031 cfg_commit while PENDING is absorbed; cfg_we while PENDING updates shadow and is included in that copy.
REQ-032 Unlock FSM states LOCKED, UNLOCKED, DRAIN; map_unlock=1 in UNLOCKED and DRAIN.
REQ-033 LOCKED->UNLOCKED on unlock_set; UNLOCKED->DRAIN on unlock_clr, loading counter with UNLOCK_HOLD-1; DRAIN decrements each cycle, ->LOCKED when counter is 0.
REQ-034 unlock_set in DRAIN returns to UNLOCKED; simultaneous unlock_set and unlock_clr: set wins.

Reset
REQ-035 RST_N low: all outputs 0, both FSMs to IDLE/LOCKED, counter 0, shadow and active tables 0 (all windows disabled).
REQ-036 Reset mid-commit discards the pending commit; reset in DRAIN forces LOCKED immediately.

Structure
REQ-037 Shared package holds field-code constants, flag bit positions, window-entry struct, FSM state encodings.
REQ-038 One sub-module addr_window_match (single-window compare and translate) instantiated NUM_WIN times.

Verification
REQ-039 Window0 base 0x008000 mask 0x408000 lorom_pack, target 0, xlat 0x3FFFFF; SNES_ADDR 0x018123 -> next cycle ROM_ADDR 0x008123, IS_ROM=1.
REQ-040 Windows 0 and 1 both match 0x700000 (1 saveram) -> win_hit=0b0001, IS_SAVERAM=0; disable 0 and commit -> win_hit=0b0010, IS_SAVERAM=1.
REQ-041 Commit with snes_idle=0 for 5 cycles: cfg_busy high 5 cycles, decode uses old table until snes_idle=1 edge.
REQ-042 unlock_set, SNES_ADDR 0xF01234 -> ROM_ADDR 0xF01234, IS_WRITABLE=1; unlock_clr with UNLOCK_HOLD=16 -> map_unlock low exactly 16 cycles later.
REQ-043 unlock_set and unlock_clr same cycle in DRAIN -> UNLOCKED, map_unlock stays high.
REQ-044 Assert RST_N low while PENDING -> cfg_busy 0, all outputs 0 asynchronously.
